// File: rtl/uart_tx.sv
// UART transmitter: AXI-Stream byte in, 8-bit LSB-first async frame out on txd.
// Optional odd/even parity, 1 or 2 stop bits, CTS gates frame start only.
module uart_tx #(
    parameter int CLOCK_FREQ = 10_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       cts,
    output logic       txd,
    output logic       busy
);

    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD    = CW'(DIV - 1);
    localparam logic [2:0]    STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;
    logic          cts_meta;
    logic          cts_sync;
    logic          xfer;
    logic          bit_done;

    assign s_tready = (state == S_IDLE) && cts_sync && !reset;
    assign xfer     = s_tvalid && s_tready;
    assign bit_done = (baud_cnt == '0);
    assign busy     = (state != S_IDLE);

    // Cleared to 0 so nothing is sent until CTS has been seen on two edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            cts_meta <= 1'b0;
            cts_sync <= 1'b0;
        end else begin
            cts_meta <= cts;
            cts_sync <= cts_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (state != S_IDLE)
                baud_cnt <= bit_done ? RELOAD : baud_cnt - CW'(1);

            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (xfer) begin
                        state    <= S_START;
                        txd      <= 1'b0;
                        shift    <= s_tdata;
                        // Parity computed from the latched byte so the shifter can consume it.
                        par_bit  <= (PARITY == 1) ? ~^s_tdata : ^s_tdata;
                        baud_cnt <= RELOAD;
                        bit_idx  <= '0;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state   <= S_DATA;
                        txd     <= shift[0];
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= S_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        state   <= S_STOP;
                        txd     <= 1'b1;
                        bit_idx <= '0;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (bit_idx == STOP_LAST) begin
                            state   <= S_IDLE;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                        txd <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle frame checks plus a line receiver model
// feeding a scoreboard that is matched against bytes accepted on the AXIS port.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       cts;
    int         sel;

    logic rdy_a, txd_a, busy_a;
    logic rdy_b, txd_b, busy_b;
    logic rdy_c, txd_c, busy_c;
    logic rdy_d, txd_d, busy_d;
    logic txd_mon, tready_mon, busy_mon;

    int mon_div   = 4;
    int mon_par   = 0;
    int mon_stops = 1;
    int rst_cnt   = 0;
    int n_cmp     = 0;
    int n_err     = 0;

    logic [7:0] exp_q[$];
    logic [9:0] rxq[$];

    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(250_000), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel == 0),
        .s_tready(rdy_a), .cts(cts), .txd(txd_a), .busy(busy_a));
    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(250_000), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel == 1),
        .s_tready(rdy_b), .cts(cts), .txd(txd_b), .busy(busy_b));
    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(250_000), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel == 2),
        .s_tready(rdy_c), .cts(cts), .txd(txd_c), .busy(busy_c));
    uart_tx u_d (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel == 3),
        .s_tready(rdy_d), .cts(cts), .txd(txd_d), .busy(busy_d));

    always #5 clk = ~clk;

    always_comb begin
        txd_mon = txd_a; tready_mon = rdy_a; busy_mon = busy_a;
        case (sel)
            1: begin txd_mon = txd_b; tready_mon = rdy_b; busy_mon = busy_b; end
            2: begin txd_mon = txd_c; tready_mon = rdy_c; busy_mon = busy_c; end
            3: begin txd_mon = txd_d; tready_mon = rdy_d; busy_mon = busy_d; end
            default: ;
        endcase
    end

    // Scoreboard producer: every accepted byte is expected back on the line.
    always @(posedge clk) begin
        if (reset) rst_cnt <= rst_cnt + 1;
        else if (s_tvalid && tready_mon) exp_q.push_back(s_tdata);
    end

    // Receiver model: mid-bit sampling; frames overlapped by a reset are dropped.
    logic [7:0] rx_d;
    logic       rx_p;
    logic       rx_ok;
    int         rx_r0;
    always begin
        @(negedge clk);
        if (txd_mon === 1'b0) begin
            rx_r0 = rst_cnt; rx_ok = 1'b1; rx_p = 1'b0;
            repeat (mon_div / 2) @(negedge clk);
            if (txd_mon !== 1'b0) rx_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (mon_div) @(negedge clk);
                rx_d[i] = txd_mon;
            end
            if (mon_par != 0) begin
                repeat (mon_div) @(negedge clk);
                rx_p = txd_mon;
            end
            for (int i = 0; i < mon_stops; i++) begin
                repeat (mon_div) @(negedge clk);
                if (txd_mon !== 1'b1) rx_ok = 1'b0;
            end
            if (rx_r0 == rst_cnt) rxq.push_back({rx_ok, rx_p, rx_d});
        end
    end

    function automatic logic exp_parity(input logic [7:0] d, input int par);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (par == 2) ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int s, input int div, input int par, input int stops);
        sel = s; mon_div = div; mon_par = par; mon_stops = stops;
    endtask

    // Leaves the caller at the first negedge of START (handshake just completed).
    task automatic send(input logic [7:0] d, input bit hold, input string tag);
        int w;
        w = 0;
        s_tdata = d; s_tvalid = 1'b1;
        while (!tready_mon && w < 3000) begin @(negedge clk); w++; end
        chk({tag, " accept"}, 32'(tready_mon), 32'd1);
        @(negedge clk);
        if (!hold) s_tvalid = 1'b0;
    endtask

    // Cycle-exact frame check; ends on the first IDLE negedge after the frame.
    task automatic check_frame(input logic [7:0] d, input int div, input int par,
                               input int stops, input string tag);
        logic [11:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        nb = 9;
        if (par != 0) begin bits[9] = exp_parity(d, par); nb = 10; end
        nb += stops;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < div; c++) begin
                chk($sformatf("%s txd bit%0d clk%0d", tag, b, c), 32'(txd_mon), 32'(bits[b]));
                chk($sformatf("%s busy bit%0d clk%0d", tag, b, c), 32'(busy_mon), 32'd1);
                @(negedge clk);
            end
        end
        chk({tag, " idle txd"}, 32'(txd_mon), 32'd1);
        chk({tag, " idle busy"}, 32'(busy_mon), 32'd0);
    endtask

    task automatic drain(input string tag);
        logic [9:0] r;
        logic [7:0] e;
        int w;
        w = 0;
        while (rxq.size() == 0 && w < 3000) begin @(negedge clk); w++; end
        chk({tag, " rx frame seen"}, 32'(rxq.size() > 0), 32'd1);
        chk({tag, " sb entry"}, 32'(exp_q.size() > 0), 32'd1);
        if (rxq.size() > 0 && exp_q.size() > 0) begin
            r = rxq.pop_front();
            e = exp_q.pop_front();
            chk({tag, " rx data"}, 32'(r[7:0]), 32'(e));
            if (mon_par != 0) chk({tag, " rx parity"}, 32'(r[8]), 32'(exp_parity(e, mon_par)));
            chk({tag, " rx framing"}, 32'(r[9]), 32'd1);
        end
    endtask

    task automatic release_cts(input string tag);
        cts = 1'b1;
        @(negedge clk); chk({tag, " tready 1clk"}, 32'(tready_mon), 32'd0);
        @(negedge clk); chk({tag, " tready 2clk"}, 32'(tready_mon), 32'd1);
        @(negedge clk); chk({tag, " start"}, 32'(txd_mon), 32'd0);
        s_tvalid = 1'b0;
    endtask

    initial begin
        int bad;
        logic [7:0] rb;
        clk = 1'b0; reset = 1'b1; cts = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        set_sel(0, 4, 0, 1);

        // 1: reset state, CTS synchroniser latency
        repeat (2) @(negedge clk);
        chk("rst txd", 32'(txd_mon), 32'd1);
        chk("rst busy", 32'(busy_mon), 32'd0);
        chk("rst tready", 32'(tready_mon), 32'd0);
        chk("rst txd default", 32'(txd_d), 32'd1);
        reset = 1'b0; cts = 1'b1;
        @(negedge clk); chk("cts 1clk tready", 32'(tready_mon), 32'd0);
        @(negedge clk); chk("cts 2clk tready", 32'(tready_mon), 32'd1);

        // 2: 0xA5, no parity, 1 stop
        send(8'hA5, 1'b0, "t2");
        check_frame(8'hA5, 4, 0, 1, "t2");
        chk("t2 tready after frame", 32'(tready_mon), 32'd1);
        drain("t2");

        // 3: parity variants and 2 stop bits
        set_sel(1, 4, 2, 1);
        send(8'h07, 1'b0, "t3e");
        check_frame(8'h07, 4, 2, 1, "t3e");
        drain("t3e");
        set_sel(2, 4, 1, 2);
        send(8'h07, 1'b0, "t3o");
        check_frame(8'h07, 4, 1, 2, "t3o");
        drain("t3o");

        // 4: back-to-back with s_tvalid held
        set_sel(0, 4, 0, 1);
        send(8'h00, 1'b1, "t4a");
        s_tdata = 8'hFF;
        check_frame(8'h00, 4, 0, 1, "t4a");
        chk("t4 gap tready", 32'(tready_mon), 32'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        check_frame(8'hFF, 4, 0, 1, "t4b");
        drain("t4a");
        drain("t4b");

        // 5: CTS stall, drop mid-frame, resume
        cts = 1'b0;
        repeat (3) @(negedge clk);
        s_tdata = 8'h3C; s_tvalid = 1'b1; bad = 0;
        repeat (100) begin
            if (txd_mon !== 1'b1 || tready_mon !== 1'b0 || busy_mon !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("t5 stall bad cycles", 32'(bad), 32'd0);
        chk("t5 no transfer", 32'(exp_q.size()), 32'd0);
        release_cts("t5a");
        cts = 1'b0;
        check_frame(8'h3C, 4, 0, 1, "t5a");
        drain("t5a");
        s_tdata = 8'hC3; s_tvalid = 1'b1; bad = 0;
        repeat (10) begin
            if (txd_mon !== 1'b1 || tready_mon !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("t5 wait bad cycles", 32'(bad), 32'd0);
        release_cts("t5b");
        check_frame(8'hC3, 4, 0, 1, "t5b");
        drain("t5b");

        // 6: reset during data bit 3, then a clean frame
        send(8'h5A, 1'b0, "t6");
        repeat (17) @(negedge clk);
        chk("t6 in bit3", 32'(txd_mon), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6 rst txd", 32'(txd_mon), 32'd1);
        chk("t6 rst busy", 32'(busy_mon), 32'd0);
        chk("t6 rst tready", 32'(tready_mon), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        bad = 0;
        repeat (50) begin
            if (txd_mon !== 1'b1 || busy_mon !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("t6 quiet after reset", 32'(bad), 32'd0);
        send(8'hC6, 1'b0, "t6b");
        check_frame(8'hC6, 4, 0, 1, "t6b");
        drain("t6b");
        chk("t6 no stale frame", 32'(rxq.size()), 32'd0);

        // 7: default parameters (DIV=86), random bytes through the receiver model
        set_sel(3, 86, 0, 1);
        for (int k = 0; k < 32; k++) begin
            rb = 8'($urandom);
            send(rb, 1'b1, "t7");
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < 32; k++) drain("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
